// File: rtl/fir_decim_quant.sv
// Decimating round-half-up quantizer with saturation and a small output FIFO.
// Sits behind a wide FIR accumulator and hands narrow samples to a ready/valid sink.
module fir_decim_quant #(
    parameter int IN_WIDTH   = 33,
    parameter int OUT_WIDTH  = 16,
    parameter int DECIM      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    input  logic signed [IN_WIDTH-1:0]  din,
    input  logic                        dout_ready,
    output logic                        dout_valid,
    output logic signed [OUT_WIDTH-1:0] dout,
    output logic                        overflow,
    output logic                        sat
);

    localparam int S    = IN_WIDTH - OUT_WIDTH;
    localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [PH_W-1:0]             PH_LAST = PH_W'(DECIM - 1);
    localparam logic [AW:0]                 CNT_FULL = (AW + 1)'(FIFO_DEPTH);
    localparam logic signed [IN_WIDTH:0]    RND   = {{IN_WIDTH{1'b0}}, 1'b1} << (S - 1);
    localparam logic signed [OUT_WIDTH-1:0] Q_MAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] Q_MIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    // Assertion is immediate; release is re-timed so no sample lands on the release edge.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    logic signed [IN_WIDTH:0]    w_rnd;
    logic signed [IN_WIDTH:0]    w_shr;
    logic [S+1:0]                w_hi;
    logic                        w_fits;
    logic                        w_sat_hi;
    logic                        w_sat_lo;
    logic signed [OUT_WIDTH-1:0] w_q;

    // One guard bit keeps the rounding add from wrapping at the positive extreme.
    assign w_rnd    = $signed({din[IN_WIDTH-1], din}) + RND;
    assign w_shr    = w_rnd >>> S;
    assign w_hi     = w_shr[IN_WIDTH:OUT_WIDTH-1];
    assign w_fits   = (&w_hi) | ~(|w_hi);
    assign w_sat_hi = ~w_fits & ~w_shr[IN_WIDTH];
    assign w_sat_lo = ~w_fits &  w_shr[IN_WIDTH];

    always_comb begin
        w_q = w_shr[OUT_WIDTH-1:0];
        if (w_sat_hi) begin
            w_q = Q_MAX;
        end else if (w_sat_lo) begin
            w_q = Q_MIN;
        end
    end

    logic [PH_W-1:0]             r_phase;
    logic                        r_q_valid;
    logic signed [OUT_WIDTH-1:0] r_q;
    logic                        r_sat;
    logic                        w_keep;

    assign w_keep = valid_in && (r_phase == '0);

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_phase   <= '0;
            r_q_valid <= 1'b0;
            r_q       <= '0;
            r_sat     <= 1'b0;
        end else begin
            r_q_valid <= w_keep;
            if (valid_in) begin
                r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PH_W'(1);
            end
            if (w_keep) begin
                r_q <= w_q;
                if (w_sat_hi || w_sat_lo) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    logic signed [OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]               r_wr_ptr;
    logic [AW-1:0]               r_rd_ptr;
    logic [AW:0]                 r_count;
    logic                        r_ovf;
    logic                        w_full;
    logic                        w_pop;
    logic                        w_push;

    // A pop on the same edge frees the slot, so a full FIFO can still accept.
    assign w_full = (r_count == CNT_FULL);
    assign w_pop  = (r_count != '0) && dout_ready;
    assign w_push = r_q_valid && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_q;
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (r_q_valid && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign dout_valid = (r_count != '0);
    assign dout       = dout_valid ? r_mem[r_rd_ptr] : '0;
    assign overflow   = r_ovf;
    assign sat        = r_sat;

endmodule

// File: tb/tb_fir_decim_quant.sv
// Directed bench for fir_decim_quant at default parameters (33 -> 16 bits, DECIM 4, depth 4).
module tb_fir_decim_quant;

    logic               clk = 1'b0;
    logic               rst;
    logic               valid_in;
    logic signed [32:0] din;
    logic               dout_ready;
    logic               dout_valid;
    logic signed [15:0] dout;
    logic               overflow;
    logic               sat;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fir_decim_quant #(
        .IN_WIDTH  (33),
        .OUT_WIDTH (16),
        .DECIM     (4),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .din       (din),
        .dout_ready(dout_ready),
        .dout_valid(dout_valid),
        .dout      (dout),
        .overflow  (overflow),
        .sat       (sat)
    );

    task tick;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        rst = 1'b0; valid_in = 1'b0; din = '0; dout_ready = 1'b0;
        #3;
        tick; tick;
        rst = 1'b1;
        tick; tick; tick;
    endtask

    task feed(input logic signed [32:0] v);
        valid_in = 1'b1; din = v;
        tick;
        valid_in = 1'b0; din = '0;
    endtask

    task test_reset;
        rst = 1'b0; valid_in = 1'b0; din = '0; dout_ready = 1'b0;
        #2;
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
        n_tests++; if (dout !== 16'sd0) begin n_fail++; $display("FAIL reset_dout: got %0d expected 0", dout); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL reset_sat: got %b expected 0", sat); end
        tick; tick;
        // sample presented only on the release edge must be ignored
        rst = 1'b1; valid_in = 1'b1; din = 33'(3 * 131072);
        tick;
        valid_in = 1'b0; din = '0; dout_ready = 1'b1;
        tick; tick; tick; tick;
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL release_edge: got valid %b expected 0", dout_valid); end
    endtask

    task test_decim;
        logic exp_v;
        do_reset;
        dout_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            valid_in = 1'b1; din = 33'(k * 131072);
            tick;
            exp_v = (k == 1) || (k == 5) || (k == 9);
            n_tests++; if (dout_valid !== exp_v) begin n_fail++; $display("FAIL decim_valid[%0d]: got %b expected %b", k, dout_valid, exp_v); end
            if (exp_v) begin
                n_tests++; if (dout !== 16'(k - 1)) begin n_fail++; $display("FAIL decim_dout[%0d]: got %0d expected %0d", k, dout, k - 1); end
            end
        end
        valid_in = 1'b0; din = '0;
        tick; tick;
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL decim_drained: got %b expected 0", dout_valid); end
        n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL decim_sat: got %b expected 0", sat); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL decim_ovf: got %b expected 0", overflow); end
    endtask

    task test_round;
        logic signed [32:0] rv [6];
        int                 rexp [6];
        rv   = '{33'sd65536, 33'sd65535, -33'sd65536, -33'sd65537, 33'h1_0000_0000, 33'h0_FFFF_FFFF};
        rexp = '{1, 0, 0, -1, -32768, 32767};
        do_reset;
        dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            feed(rv[i]);
            feed('0);
            n_tests++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL round_valid[%0d]: got %b expected 1", i, dout_valid); end
            n_tests++; if (dout !== 16'(rexp[i])) begin n_fail++; $display("FAIL round_dout[%0d]: got %0d expected %0d", i, dout, rexp[i]); end
            if (i == 4) begin
                n_tests++; if (sat !== 1'b0) begin n_fail++; $display("FAIL round_sat_min: got %b expected 0", sat); end
            end
            if (i == 5) begin
                n_tests++; if (sat !== 1'b1) begin n_fail++; $display("FAIL round_sat_max: got %b expected 1", sat); end
            end
            feed('0);
            feed('0);
        end
    endtask

    task test_gaps;
        int got;
        got = 0;
        do_reset;
        dout_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            for (int j = 0; j < 3; j++) begin
                valid_in = (j == 0);
                din = (j == 0) ? 33'(k * 131072) : 33'h1_2345_6789;
                tick;
                if (dout_valid === 1'b1) begin
                    n_tests++; if (got >= 3 || dout !== 16'(got * 4)) begin n_fail++; $display("FAIL gaps_dout[%0d]: got %0d expected %0d", got, dout, got * 4); end
                    got++;
                end
            end
        end
        valid_in = 1'b0; din = '0;
        tick; tick;
        n_tests++; if (got != 3) begin n_fail++; $display("FAIL gaps_count: got %0d outputs expected 3", got); end
    endtask

    task test_overflow;
        do_reset;
        dout_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            feed(33'(v * 131072));
            feed('0); feed('0); feed('0);
            if (v == 4) begin
                n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", overflow); end
            end
        end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        n_tests++; if (dout_valid !== 1'b1 || dout !== 16'sd1) begin n_fail++; $display("FAIL ovf_head: got v=%b d=%0d expected v=1 d=1", dout_valid, dout); end
        dout_ready = 1'b1;
        for (int j = 2; j <= 4; j++) begin
            tick;
            n_tests++; if (dout_valid !== 1'b1 || dout !== 16'(j)) begin n_fail++; $display("FAIL ovf_drain[%0d]: got v=%b d=%0d expected v=1 d=%0d", j, dout_valid, dout, j); end
        end
        tick;
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b expected 0", dout_valid); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task test_back_to_back;
        do_reset;
        dout_ready = 1'b0;
        for (int v = 1; v <= 4; v++) begin
            feed(33'(v * 10 * 131072));
            feed('0); feed('0); feed('0);
        end
        feed(33'(50 * 131072));
        dout_ready = 1'b1;
        feed('0);
        dout_ready = 1'b0;
        n_tests++; if (dout_valid !== 1'b1 || dout !== 16'sd20) begin n_fail++; $display("FAIL b2b_head: got v=%b d=%0d expected v=1 d=20", dout_valid, dout); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b expected 0", overflow); end
        tick;
        n_tests++; if (dout !== 16'sd20) begin n_fail++; $display("FAIL b2b_stall: got %0d expected 20", dout); end
        dout_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n_tests++; if (dout_valid !== 1'b1 || dout !== 16'(20 + 10 * j)) begin n_fail++; $display("FAIL b2b_drain[%0d]: got v=%b d=%0d expected v=1 d=%0d", j, dout_valid, dout, 20 + 10 * j); end
            tick;
        end
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b expected 0", dout_valid); end
    endtask

    task test_reset_mid;
        do_reset;
        dout_ready = 1'b0;
        feed(33'(1 * 131072));
        feed('0); feed('0); feed('0);
        feed(33'(2 * 131072));
        feed('0);
        n_tests++; if (dout_valid !== 1'b1 || dout !== 16'sd1) begin n_fail++; $display("FAIL mid_pre: got v=%b d=%0d expected v=1 d=1", dout_valid, dout); end
        #3;
        rst = 1'b0;
        #1;
        n_tests++; if (dout_valid !== 1'b0 || dout !== 16'sd0) begin n_fail++; $display("FAIL mid_async: got v=%b d=%0d expected v=0 d=0", dout_valid, dout); end
        tick;
        rst = 1'b1;
        tick; tick; tick;
        dout_ready = 1'b1;
        n_tests++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL mid_flushed: got %b expected 0", dout_valid); end
        feed(33'(7 * 131072));
        tick;
        n_tests++; if (dout_valid !== 1'b1 || dout !== 16'sd7) begin n_fail++; $display("FAIL mid_first: got v=%b d=%0d expected v=1 d=7", dout_valid, dout); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset;
        test_decim;
        test_round;
        test_gaps;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
